// File: rtl/eco32_core_lsu_dcm_seq.sv
// Data-cache miss sequencer: optional dirty-line writeback, then line refill.
// Optional refill watchdog enabled by defining ECO32_LSU_DCM_SEQ_WDOG_EN.
module eco32_core_lsu_dcm_seq #(
    parameter int LINE_LOG2 = 3,
    parameter int WDOG_MAX  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   f_stb,
    input  logic                   f_tid,
    input  logic                   f_dirty,
    input  logic [6:0]             f_page,
    input  logic [31:0]            f_p_addr,
    input  logic [31:0]            f_k_addr,
    output logic                   f_ack,
    output logic                   m_req_stb,
    output logic                   m_req_wr,
    output logic [31:0]            m_req_addr,
    input  logic                   m_req_rdy,
    output logic                   m_wr_stb,
    output logic [31:0]            m_wr_dat,
    input  logic                   m_rd_stb,
    input  logic [31:0]            m_rd_dat,
    output logic                   c_rd_stb,
    output logic                   c_wr_stb,
    output logic [6+LINE_LOG2:0]   c_addr,
    input  logic [31:0]            c_rd_dat,
    output logic [31:0]            c_wr_dat,
    output logic                   d_stb,
    output logic                   d_tid,
    output logic                   d_err
);

    localparam int OFS = LINE_LOG2 + 2;
    localparam logic [LINE_LOG2-1:0] LAST = '1;

    typedef enum logic [2:0] {
        IDLE, WB_REQ, WB_DATA, WB_FLUSH, RF_REQ, RF_DATA, DONE
    } state_t;

    state_t                 state;
    logic [LINE_LOG2-1:0]   cnt;
    logic [LINE_LOG2-1:0]   cnt_inc;
    logic [31:0]            k_line;
    logic [31:0]            p_line;
    logic                   unused_addr_bits;

    assign cnt_inc = cnt + 1'b1;
    assign k_line  = {f_k_addr[31:OFS], {OFS{1'b0}}};
    assign p_line  = {f_p_addr[31:OFS], {OFS{1'b0}}};
    assign unused_addr_bits = ^{f_k_addr[OFS-1:0], f_p_addr[OFS-1:0]};

    // Cache read data lands one cycle after the read strobe, alongside m_wr_stb.
    assign m_wr_dat = m_wr_stb ? c_rd_dat : '0;

`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam logic [WW-1:0] WLIM = WW'(WDOG_MAX - 1);
    logic [WW-1:0] wdog;
    logic          err_q;
    assign d_err = err_q;
`else
    assign d_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            f_ack      <= 1'b0;
            m_req_stb  <= 1'b0;
            m_req_wr   <= 1'b0;
            m_req_addr <= '0;
            m_wr_stb   <= 1'b0;
            c_rd_stb   <= 1'b0;
            c_wr_stb   <= 1'b0;
            c_addr     <= '0;
            c_wr_dat   <= '0;
            d_stb      <= 1'b0;
            d_tid      <= 1'b0;
`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
            wdog       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            f_ack    <= 1'b0;
            d_stb    <= 1'b0;
            c_wr_stb <= 1'b0;
            m_wr_stb <= c_rd_stb;
            unique case (state)
                IDLE: begin
                    if (f_stb) begin
                        m_req_stb  <= 1'b1;
                        m_req_wr   <= f_dirty;
                        m_req_addr <= f_dirty ? k_line : p_line;
                        state      <= f_dirty ? WB_REQ : RF_REQ;
                    end
                end
                WB_REQ: begin
                    if (m_req_rdy) begin
                        m_req_stb <= 1'b0;
                        m_req_wr  <= 1'b0;
                        cnt       <= '0;
                        c_rd_stb  <= 1'b1;
                        c_addr    <= {f_page, {LINE_LOG2{1'b0}}};
                        state     <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    cnt    <= cnt_inc;
                    c_addr <= {f_page, cnt_inc};
                    if (cnt == LAST) begin
                        c_rd_stb <= 1'b0;
                        state    <= WB_FLUSH;
                    end
                end
                WB_FLUSH: begin
                    m_req_stb  <= 1'b1;
                    m_req_wr   <= 1'b0;
                    m_req_addr <= p_line;
                    state      <= RF_REQ;
                end
                RF_REQ: begin
                    if (m_req_rdy) begin
                        m_req_stb <= 1'b0;
                        cnt       <= '0;
`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
                        wdog      <= '0;
`endif
                        state     <= RF_DATA;
                    end
                end
                RF_DATA: begin
                    if (m_rd_stb) begin
                        c_wr_stb <= 1'b1;
                        c_addr   <= {f_page, cnt};
                        c_wr_dat <= m_rd_dat;
                        cnt      <= cnt_inc;
`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
                        wdog     <= '0;
`endif
                        if (cnt == LAST) begin
                            f_ack <= 1'b1;
                            d_stb <= 1'b1;
                            d_tid <= f_tid;
                            state <= DONE;
                        end
                    end
`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
                    // Silent memory: give up, LSU invalidates the partial line.
                    else if (wdog == WLIM) begin
                        f_ack <= 1'b1;
                        d_stb <= 1'b1;
                        d_tid <= f_tid;
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                DONE: begin
`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eco32_core_lsu_dcm_seq.sv
// Scoreboard bench for the data-cache miss sequencer.
// Watchdog scenario runs only when ECO32_LSU_DCM_SEQ_WDOG_EN is defined.
module tb_eco32_core_lsu_dcm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_stb = 1'b0;
    logic        f_tid = 1'b0;
    logic        f_dirty = 1'b0;
    logic [6:0]  f_page = '0;
    logic [31:0] f_p_addr = '0;
    logic [31:0] f_k_addr = '0;
    logic        f_ack;
    logic        m_req_stb;
    logic        m_req_wr;
    logic [31:0] m_req_addr;
    logic        m_req_rdy = 1'b0;
    logic        m_wr_stb;
    logic [31:0] m_wr_dat;
    logic        m_rd_stb = 1'b0;
    logic [31:0] m_rd_dat = '0;
    logic        c_rd_stb;
    logic        c_wr_stb;
    logic [9:0]  c_addr;
    logic [31:0] c_rd_dat = '0;
    logic [31:0] c_wr_dat;
    logic        d_stb;
    logic        d_tid;
    logic        d_err;

    eco32_core_lsu_dcm_seq #(.LINE_LOG2(3), .WDOG_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .f_stb(f_stb), .f_tid(f_tid), .f_dirty(f_dirty), .f_page(f_page),
        .f_p_addr(f_p_addr), .f_k_addr(f_k_addr), .f_ack(f_ack),
        .m_req_stb(m_req_stb), .m_req_wr(m_req_wr),
        .m_req_addr(m_req_addr), .m_req_rdy(m_req_rdy),
        .m_wr_stb(m_wr_stb), .m_wr_dat(m_wr_dat),
        .m_rd_stb(m_rd_stb), .m_rd_dat(m_rd_dat),
        .c_rd_stb(c_rd_stb), .c_wr_stb(c_wr_stb), .c_addr(c_addr),
        .c_rd_dat(c_rd_dat), .c_wr_dat(c_wr_dat),
        .d_stb(d_stb), .d_tid(d_tid), .d_err(d_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    logic [63:0] req_q[$];
    logic [63:0] crd_q[$];
    logic [63:0] mwr_q[$];
    logic [63:0] cwr_q[$];
    logic [63:0] done_q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cdat(input logic [9:0] a);
        return 32'hC0DE_0000 ^ {22'd0, a};
    endfunction

    // Cache data RAM model: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (c_rd_stb) c_rd_dat <= cdat(c_addr);
    end

    logic crd_d = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            crd_d = 1'b0;
        end else begin
            if (m_req_stb && m_req_rdy) begin
                if (req_q.size() == 0) chk("req_extra", 1, 0);
                else chk("req", {31'd0, m_req_wr, m_req_addr}, req_q.pop_front());
            end
            if (c_rd_stb) begin
                if (crd_q.size() == 0) chk("crd_extra", 1, 0);
                else chk("crd", {54'd0, c_addr}, crd_q.pop_front());
            end
            if (m_wr_stb) begin
                if (mwr_q.size() == 0) chk("mwr_extra", 1, 0);
                else chk("mwr", {32'd0, m_wr_dat}, mwr_q.pop_front());
            end
            if (m_wr_stb || crd_d) chk("wr_lag", {63'd0, m_wr_stb}, {63'd0, crd_d});
            crd_d = c_rd_stb;
            if (c_wr_stb) begin
                if (cwr_q.size() == 0) chk("cwr_extra", 1, 0);
                else chk("cwr", {22'd0, c_addr, c_wr_dat}, cwr_q.pop_front());
            end
            if (d_stb) begin
                if (done_q.size() == 0) chk("done_extra", 1, 0);
                else chk("done", {62'd0, d_tid, d_err}, done_q.pop_front());
            end
            if (f_ack != d_stb) chk("ack_pair", {63'd0, f_ack}, {63'd0, d_stb});
        end
    end

    task automatic set_head(input logic tid, input logic dirty,
                            input logic [6:0] page,
                            input logic [31:0] paddr, input logic [31:0] kaddr);
        f_tid = tid; f_dirty = dirty; f_page = page;
        f_p_addr = paddr; f_k_addr = kaddr; f_stb = 1'b1;
    endtask

    task automatic push_exp(input logic tid, input logic dirty,
                            input logic [6:0] page,
                            input logic [31:0] paddr, input logic [31:0] kaddr,
                            input logic [31:0] base, input logic err,
                            input int nbeats);
        if (dirty) begin
            req_q.push_back({31'd0, 1'b1, kaddr & ~32'h1F});
            for (int k = 0; k < 8; k++) begin
                crd_q.push_back({54'd0, page, 3'(k)});
                mwr_q.push_back({32'd0, cdat({page, 3'(k)})});
            end
        end
        req_q.push_back({31'd0, 1'b0, paddr & ~32'h1F});
        for (int k = 0; k < nbeats; k++)
            cwr_q.push_back({22'd0, page, 3'(k), base + 32'(k)});
        done_q.push_back({62'd0, tid, err});
    endtask

    task automatic serve_req(input int delay);
        int n;
        logic [31:0] a0;
        n = 0;
        while (!m_req_stb && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("req_seen", {63'd0, m_req_stb}, 1);
        a0 = m_req_addr;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            chk("req_hold", {31'd0, m_req_stb, m_req_addr}, {31'd0, 1'b1, a0});
            chk("bp_quiet", {61'd0, c_rd_stb, m_wr_stb, c_wr_stb}, 0);
        end
        m_req_rdy = 1'b1;
        @(posedge clk); #1;
        m_req_rdy = 1'b0;
    endtask

    task automatic serve_refill(input logic [31:0] base, input int gap,
                                input int n);
        for (int k = 0; k < n; k++) begin
            m_rd_stb = 1'b1;
            m_rd_dat = base + 32'(k);
            @(posedge clk); #1;
            m_rd_stb = 1'b0;
            m_rd_dat = '0;
            if (k == 7) chk("d_lat", {63'd0, d_stb}, 1);
            if (k < n - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(input int t0, output int lat);
        int n;
        n = 0;
        while (!d_stb && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("done_seen", {63'd0, d_stb}, 1);
        chk("f_ack", {63'd0, f_ack}, 1);
        lat = cyc - t0;
        f_stb = 1'b0;
    endtask

    task automatic run_miss(input logic tid, input logic dirty,
                            input logic [6:0] page,
                            input logic [31:0] paddr, input logic [31:0] kaddr,
                            input logic [31:0] base, input int delay,
                            input int gap, output int lat);
        int t0;
        set_head(tid, dirty, page, paddr, kaddr);
        push_exp(tid, dirty, page, paddr, kaddr, base, 1'b0, 8);
        t0 = cyc;
        if (dirty) serve_req(delay);
        serve_req(delay);
        serve_refill(base, gap, 8);
        wait_done(t0, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb", {58'd0, f_ack, m_req_stb, m_wr_stb, c_rd_stb,
                        c_wr_stb, d_stb}, 0);
        chk("rst_addr", {22'd0, c_addr, m_req_addr}, 0);
        chk("rst_dat", {c_wr_dat, m_wr_dat}, 0);
        chk("rst_d", {61'd0, d_tid, d_err, m_req_wr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // clean miss, data 0..7
        run_miss(1'b1, 1'b0, 7'd5, 32'h0000_1234, 32'h0, 32'd0, 0, 0, lat);
        chk("lat_clean", 64'(lat), 10);

        // dirty miss
        run_miss(1'b0, 1'b1, 7'h11, 32'h0000_5678, 32'h0000_A0E4,
                 32'h100, 0, 0, lat);

        // request backpressure on both bursts
        run_miss(1'b1, 1'b1, 7'h7F, 32'hFFFF_FFFF, 32'h8000_0020,
                 32'hA5A5_0000, 5, 0, lat);

        // gapped refill, beat every 3rd cycle
        run_miss(1'b0, 1'b0, 7'h40, 32'h1357_9BDF, 32'h0, 32'h200, 0, 2, lat);

        // stray refill beats while idle are ignored
        @(posedge clk); #1;
        m_rd_stb = 1'b1; m_rd_dat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_rd_stb = 1'b0;
        @(posedge clk); #1;
        chk("stray", {62'd0, c_wr_stb, m_req_stb}, 0);

        // reset in the middle of the writeback, at beat 3
        set_head(1'b0, 1'b1, 7'h22, 32'h0000_3000, 32'h0000_B040);
        push_exp(1'b0, 1'b1, 7'h22, 32'h0000_3000, 32'h0000_B040,
                 32'h300, 1'b0, 8);
        serve_req(0);
        n = 0;
        while (!(c_rd_stb && c_addr[2:0] == 3'd3) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("wb3_seen", {63'd0, c_rd_stb}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst", {57'd0, f_ack, m_req_stb, m_wr_stb, c_rd_stb,
                        c_wr_stb, d_stb, d_err}, 0);
        req_q.delete(); crd_q.delete(); mwr_q.delete();
        cwr_q.delete(); done_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(1'b0, 1'b1, 7'h22, 32'h0000_3000, 32'h0000_B040,
                 32'h300, 1'b0, 8);
        begin
            int t0;
            t0 = cyc;
            serve_req(0);
            serve_req(0);
            serve_refill(32'h300, 0, 8);
            wait_done(t0, lat);
        end

        // back-to-back random misses
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pa, ka;
            pa = $urandom;
            ka = $urandom;
            run_miss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     7'($urandom), pa, ka, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 2), lat);
        end

`ifdef ECO32_LSU_DCM_SEQ_WDOG_EN
        set_head(1'b1, 1'b0, 7'h0A, 32'h0000_4440, 32'h0);
        push_exp(1'b1, 1'b0, 7'h0A, 32'h0000_4440, 32'h0,
                 32'h77, 1'b1, 2);
        serve_req(0);
        serve_refill(32'h77, 0, 2);
        repeat (15) begin @(posedge clk); #1; end
        chk("wd_early", {63'd0, d_stb}, 0);
        @(posedge clk); #1;
        chk("wd_fire", {62'd0, d_stb, d_err}, 3);
        wait_done(cyc, lat);
`endif

        repeat (4) begin @(posedge clk); #1; end
        chk("q_left", 64'(req_q.size() + crd_q.size() + mwr_q.size()
                          + cwr_q.size() + done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
